// File: rtl/skullfet_sr_bank.sv
// Bank of clocked SR storage channels with input synchronisers,
// selectable conflict policy, sticky conflict flags and a transition counter.
module skullfet_sr_bank #(
  parameter int CHANNELS    = 4,
  parameter int MODE        = 0,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CHANNELS-1:0]  set,
  input  logic [CHANNELS-1:0]  reset,
  input  logic                 clear_flags,
  output logic [CHANNELS-1:0]  q,
  output logic [CHANNELS-1:0]  q_bar,
  output logic [CHANNELS-1:0]  conflict,
  output logic [CNT_WIDTH-1:0] toggle_count
);

  localparam int SW = CNT_WIDTH + 4;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  if (CHANNELS < 1 || CHANNELS > 8) begin : g_bad_channels
    $error("skullfet_sr_bank: CHANNELS must be 1..8");
  end
  if (MODE < 0 || MODE > 3) begin : g_bad_mode
    $error("skullfet_sr_bank: MODE must be 0..3");
  end
  if (SYNC_STAGES < 0 || SYNC_STAGES > 3) begin : g_bad_sync
    $error("skullfet_sr_bank: SYNC_STAGES must be 0..3");
  end
  if (CNT_WIDTH < 2 || CNT_WIDTH > 16) begin : g_bad_cnt
    $error("skullfet_sr_bank: CNT_WIDTH must be 2..16");
  end

  logic [CHANNELS-1:0]  s_i;
  logic [CHANNELS-1:0]  r_i;
  logic [CHANNELS-1:0]  q_next;
  logic [CHANNELS-1:0]  conflict_next;
  logic [3:0]           flips;
  logic [SW-1:0]        cnt_base;
  logic [SW-1:0]        cnt_sum;
  logic [CNT_WIDTH-1:0] cnt_next;

  if (SYNC_STAGES == 0) begin : g_bypass
    assign s_i = set;
    assign r_i = reset;
  end else begin : g_sync
    logic [CHANNELS-1:0] s_ff [SYNC_STAGES];
    logic [CHANNELS-1:0] r_ff [SYNC_STAGES];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < SYNC_STAGES; i++) begin
          s_ff[i] <= '0;
          r_ff[i] <= '0;
        end
      end else begin
        s_ff[0] <= set;
        r_ff[0] <= reset;
        for (int i = 1; i < SYNC_STAGES; i++) begin
          s_ff[i] <= s_ff[i-1];
          r_ff[i] <= r_ff[i-1];
        end
      end
    end

    assign s_i = s_ff[SYNC_STAGES-1];
    assign r_i = r_ff[SYNC_STAGES-1];
  end

  function automatic logic resolve(input logic cur);
    case (MODE)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return cur;
      default: return ~cur;
    endcase
  endfunction

  always_comb begin
    q_next = q;
    for (int i = 0; i < CHANNELS; i++) begin
      unique case (1'b1)
        s_i[i] & ~r_i[i]: q_next[i] = 1'b1;
        ~s_i[i] & r_i[i]: q_next[i] = 1'b0;
        s_i[i] & r_i[i]:  q_next[i] = resolve(q[i]);
        default:          q_next[i] = q[i];
      endcase
    end
  end

  // A conflict arriving on the clearing edge survives the clear.
  assign conflict_next =
    (clear_flags ? '0 : conflict) | (s_i & r_i);

  always_comb begin
    flips = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      flips = flips + {3'b000, q_next[i] ^ q[i]};
    end
  end

  // Clearing reloads with this edge's transitions so none are lost.
  assign cnt_base = clear_flags ? '0 : SW'(toggle_count);
  assign cnt_sum  = cnt_base + SW'(flips);
  assign cnt_next = (cnt_sum > SW'(CNT_MAX)) ?
                    CNT_MAX : cnt_sum[CNT_WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q            <= '0;
      q_bar        <= '1;
      conflict     <= '0;
      toggle_count <= '0;
    end else begin
      q            <= q_next;
      q_bar        <= ~q_next;
      conflict     <= conflict_next;
      toggle_count <= cnt_next;
    end
  end

endmodule

// File: tb/tb_skullfet_sr_bank.sv
// Bench for skullfet_sr_bank: six parameter variants driven in parallel
// and compared against a rule-level reference model.
module tb_skullfet_sr_bank;

  localparam int NI = 6;

  function automatic int p_mode(input int g);
    return (g < 4) ? g : ((g == 4) ? 3 : 0);
  endfunction
  function automatic int p_sync(input int g);
    return (g == 5) ? 0 : 2;
  endfunction
  function automatic int p_cw(input int g);
    return (g == 4) ? 4 : 8;
  endfunction

  logic       clk;
  logic       rst;
  logic [3:0] set;
  logic [3:0] reset;
  logic       clear_flags;

  logic [3:0]  q_o   [NI];
  logic [3:0]  qb_o  [NI];
  logic [3:0]  cf_o  [NI];
  logic [15:0] cnt_o [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int CW = p_cw(g);
    logic [CW-1:0] tc;
    skullfet_sr_bank #(
      .CHANNELS(4),
      .MODE(p_mode(g)),
      .SYNC_STAGES(p_sync(g)),
      .CNT_WIDTH(CW)
    ) u_dut (
      .clk(clk),
      .rst(rst),
      .set(set),
      .reset(reset),
      .clear_flags(clear_flags),
      .q(q_o[g]),
      .q_bar(qb_o[g]),
      .conflict(cf_o[g]),
      .toggle_count(tc)
    );
    assign cnt_o[g] = 16'(tc);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;

  // Reference model state
  logic [3:0] mq  [NI];
  logic [3:0] mcf [NI];
  int         mcnt[NI];
  logic [3:0] hs  [4];
  logic [3:0] hr  [4];

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      mq[k] = '0; mcf[k] = '0; mcnt[k] = 0;
    end
    for (int i = 0; i < 4; i++) begin
      hs[i] = '0; hr[i] = '0;
    end
  endtask

  task automatic model_edge();
    logic [3:0] s, r, nq;
    int flips, mx, c;
    for (int i = 3; i > 0; i--) begin
      hs[i] = hs[i-1]; hr[i] = hr[i-1];
    end
    hs[0] = set; hr[0] = reset;
    for (int k = 0; k < NI; k++) begin
      s = hs[p_sync(k)];
      r = hr[p_sync(k)];
      nq = mq[k];
      for (int b = 0; b < 4; b++) begin
        if (s[b] && !r[b]) nq[b] = 1'b1;
        else if (!s[b] && r[b]) nq[b] = 1'b0;
        else if (s[b] && r[b]) begin
          case (p_mode(k))
            0: nq[b] = 1'b0;
            1: nq[b] = 1'b1;
            2: nq[b] = mq[k][b];
            default: nq[b] = ~mq[k][b];
          endcase
        end
      end
      flips = $countones(nq ^ mq[k]);
      mx = (1 << p_cw(k)) - 1;
      c = clear_flags ? flips : mcnt[k] + flips;
      mcnt[k] = (c > mx) ? mx : c;
      mcf[k] = (clear_flags ? 4'b0 : mcf[k]) | (s & r);
      mq[k] = nq;
    end
  endtask

  task automatic step(input logic [3:0] s, input logic [3:0] r,
                      input logic clr);
    set = s;
    reset = r;
    clear_flags = clr;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    model_reset();
    set = '0; reset = '0; clear_flags = 1'b0;
    #2 rst = 1'b0;
  endtask

  task automatic test_reset();
    step(4'hF, 4'h0, 1'b0);
    step(4'hF, 4'h0, 1'b0);
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < NI; k++) begin
      n_chk += 4;
      if (q_o[k] !== 4'h0) begin
        n_fail++;
        $display("FAIL reset_q[%0d] got %h exp 0", k, q_o[k]);
      end
      if (qb_o[k] !== 4'hF) begin
        n_fail++;
        $display("FAIL reset_qbar[%0d] got %h exp f", k, qb_o[k]);
      end
      if (cf_o[k] !== 4'h0) begin
        n_fail++;
        $display("FAIL reset_conf[%0d] got %h exp 0", k, cf_o[k]);
      end
      if (cnt_o[k] !== 16'd0) begin
        n_fail++;
        $display("FAIL reset_cnt[%0d] got %0d exp 0", k, cnt_o[k]);
      end
    end
    model_reset();
    set = '0;
    #1 rst = 1'b0;
    for (int j = 0; j < 3; j++) begin
      step(4'h0, 4'h0, 1'b0);
      for (int k = 0; k < NI; k++) begin
        n_chk++;
        if (q_o[k] !== 4'h0) begin
          n_fail++;
          $display("FAIL post_reset_q[%0d] got %h exp 0", k, q_o[k]);
        end
      end
    end
  endtask

  task automatic test_latency();
    logic [3:0] exp0 [3] = '{4'h0, 4'h0, 4'h1};
    for (int j = 0; j < 3; j++) begin
      step((j == 0) ? 4'h1 : 4'h0, 4'h0, 1'b0);
      n_chk++;
      if (q_o[0] !== exp0[j]) begin
        n_fail++;
        $display("FAIL latency_q edge%0d got %h exp %h", j, q_o[0], exp0[j]);
      end
      if (j == 0) begin
        n_chk++;
        if (q_o[5] !== 4'h1) begin
          n_fail++;
          $display("FAIL bypass_latency_q got %h exp 1", q_o[5]);
        end
      end
    end
    n_chk += 2;
    if (qb_o[0] !== 4'hE) begin
      n_fail++;
      $display("FAIL latency_qbar got %h exp e", qb_o[0]);
    end
    if (cnt_o[0] !== 16'd1) begin
      n_fail++;
      $display("FAIL latency_cnt got %0d exp 1", cnt_o[0]);
    end
    step(4'h0, 4'h1, 1'b0);
    step(4'h0, 4'h0, 1'b0);
    step(4'h0, 4'h0, 1'b0);
    n_chk += 2;
    if (q_o[0] !== 4'h0) begin
      n_fail++;
      $display("FAIL latency_clr_q got %h exp 0", q_o[0]);
    end
    if (cnt_o[0] !== 16'd2) begin
      n_fail++;
      $display("FAIL latency_clr_cnt got %0d exp 2", cnt_o[0]);
    end
  endtask

  task automatic test_conflict_modes();
    logic [3:0] expq [4] = '{4'h0, 4'h1, 4'h0, 4'h0};
    do_reset();
    for (int j = 0; j < 6; j++) begin
      step((j < 4) ? 4'h1 : 4'h0, (j < 4) ? 4'h1 : 4'h0, 1'b0);
      if (j >= 2) begin
        n_chk++;
        if (q_o[3] !== mq[3]) begin
          n_fail++;
          $display("FAIL toggle_q edge%0d got %h exp %h", j, q_o[3], mq[3]);
        end
      end
    end
    for (int k = 0; k < 4; k++) begin
      n_chk += 2;
      if (q_o[k] !== expq[k]) begin
        n_fail++;
        $display("FAIL mode%0d_q got %h exp %h", k, q_o[k], expq[k]);
      end
      if (cf_o[k] !== 4'h1) begin
        n_fail++;
        $display("FAIL mode%0d_conf got %h exp 1", k, cf_o[k]);
      end
    end
    n_chk++;
    if (cnt_o[3] !== 16'd4) begin
      n_fail++;
      $display("FAIL mode3_cnt got %0d exp 4", cnt_o[3]);
    end
  endtask

  task automatic test_sticky();
    do_reset();
    step(4'h4, 4'h4, 1'b0);
    step(4'h0, 4'h0, 1'b0);
    step(4'h0, 4'h0, 1'b0);
    n_chk++;
    if (cf_o[0] !== 4'h4) begin
      n_fail++;
      $display("FAIL sticky_set got %h exp 4", cf_o[0]);
    end
    step(4'h0, 4'h0, 1'b1);
    n_chk++;
    if (cf_o[0] !== 4'h0) begin
      n_fail++;
      $display("FAIL sticky_clear got %h exp 0", cf_o[0]);
    end
    step(4'h4, 4'h4, 1'b0);
    step(4'h0, 4'h0, 1'b0);
    step(4'h0, 4'h0, 1'b1);
    n_chk++;
    if (cf_o[0] !== 4'h4) begin
      n_fail++;
      $display("FAIL sticky_clear_vs_new got %h exp 4", cf_o[0]);
    end
    for (int k = 0; k < NI; k++) begin
      n_chk++;
      if (cf_o[k] !== mcf[k]) begin
        n_fail++;
        $display("FAIL sticky_model[%0d] got %h exp %h", k, cf_o[k], mcf[k]);
      end
    end
  endtask

  task automatic test_saturation();
    int expc [7] = '{0, 0, 4, 8, 12, 15, 15};
    do_reset();
    for (int j = 0; j < 7; j++) begin
      step(4'hF, 4'hF, 1'b0);
      n_chk++;
      if (cnt_o[4] !== 16'(expc[j])) begin
        n_fail++;
        $display("FAIL sat_cnt edge%0d got %0d exp %0d", j, cnt_o[4], expc[j]);
      end
    end
    step(4'hF, 4'hF, 1'b1);
    n_chk++;
    if (cnt_o[4] !== 16'd4) begin
      n_fail++;
      $display("FAIL sat_clear_cnt got %0d exp 4", cnt_o[4]);
    end
  endtask

  task automatic test_bypass();
    do_reset();
    step(4'h8, 4'h0, 1'b0);
    n_chk += 2;
    if (q_o[5] !== 4'h8) begin
      n_fail++;
      $display("FAIL bypass_q got %h exp 8", q_o[5]);
    end
    if (q_o[0] !== 4'h0) begin
      n_fail++;
      $display("FAIL bypass_sync_q got %h exp 0", q_o[0]);
    end
  endtask

  task automatic test_random();
    logic [3:0] s, r;
    for (int j = 0; j < 400; j++) begin
      if ($urandom_range(0, 59) == 0) do_reset();
      s = 4'($urandom);
      r = 4'($urandom);
      step(s, r, ($urandom_range(0, 5) == 0));
      for (int k = 0; k < NI; k++) begin
        n_chk += 4;
        if (q_o[k] !== mq[k]) begin
          n_fail++;
          $display("FAIL rnd_q[%0d] step%0d got %h exp %h", k, j, q_o[k], mq[k]);
        end
        if (qb_o[k] !== ~mq[k]) begin
          n_fail++;
          $display("FAIL rnd_qbar[%0d] step%0d got %h exp %h",
                   k, j, qb_o[k], ~mq[k]);
        end
        if (cf_o[k] !== mcf[k]) begin
          n_fail++;
          $display("FAIL rnd_conf[%0d] step%0d got %h exp %h",
                   k, j, cf_o[k], mcf[k]);
        end
        if (cnt_o[k] !== 16'(mcnt[k])) begin
          n_fail++;
          $display("FAIL rnd_cnt[%0d] step%0d got %0d exp %0d",
                   k, j, cnt_o[k], mcnt[k]);
        end
      end
    end
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst = 1'b1;
    set = '0;
    reset = '0;
    clear_flags = 1'b0;
    model_reset();
    #12 rst = 1'b0;
    test_reset();
    test_latency();
    test_conflict_modes();
    test_sticky();
    test_saturation();
    test_bypass();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
